// File: rtl/stb_pkg.sv
// -----------------------------------------------------------------------------
// stb_pkg
// Shared types and sizing for the store buffer.
//   STB_DEPTH_DEF : default number of store entries (power of 2, >= 2)
//   STB_AW/STB_DW : word-address and data widths of an entry
//   PTR_W         : head/tail pointer width for the default depth
//   stb_entry_t   : one buffered store {valid, addr, data}
// Optional build macro used by the buffer: STB_MERGE_EN.
// -----------------------------------------------------------------------------
package stb_pkg;

  localparam int STB_DEPTH_DEF = 4;
  localparam int STB_AW        = 32;
  localparam int STB_DW        = 32;
  localparam int PTR_W         = $clog2(STB_DEPTH_DEF);

  typedef struct packed {
    logic              valid;
    logic [STB_AW-1:0] addr;
    logic [STB_DW-1:0] data;
  } stb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// -----------------------------------------------------------------------------
// store_buffer_if
// Bundles the core store port, the core load port and the data-memory port of
// the store buffer.
//   st_valid/st_ready/st_addr/st_data : store from the core
//   ld_valid/ld_addr/ld_data/ld_hit   : load from the core (owns the memory port)
//   mem_we/mem_addr/mem_wd/mem_rd     : single-port data memory, combinational read
// Modports: master = core + memory side, slave = store buffer.
//
// Handshake: a store transfers on a rising clk edge where st_valid && st_ready
// are both high. st_ready does not depend on st_valid. A load has no handshake:
// ld_valid means the load happens this cycle and its result (ld_data/ld_hit) is
// valid in the same cycle; the memory port is given to the load.
// -----------------------------------------------------------------------------
interface store_buffer_if
  import stb_pkg::*;
#(
  parameter int AW = STB_AW,
  parameter int DW = STB_DW
);

  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;

  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_hit;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rd,
    input  st_ready, ld_data, ld_hit, mem_we, mem_addr, mem_wd
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rd,
    output st_ready, ld_data, ld_hit, mem_we, mem_addr, mem_wd
  );

endinterface

// File: rtl/stb_fwd_match.sv
// -----------------------------------------------------------------------------
// stb_fwd_match
// Parallel address compare over all entries with youngest-first priority.
//   i_entries   : entry array of the buffer
//   i_head      : index of the oldest entry
//   i_addr      : address to look up
//   i_skip_head : ignore the head entry (used by the merge lookup)
//   o_hit       : some valid (non-skipped) entry matches
//   o_idx       : index of the youngest matching entry
// -----------------------------------------------------------------------------
module stb_fwd_match
  import stb_pkg::*;
#(
  parameter int DEPTH = STB_DEPTH_DEF,
  localparam int PW   = $clog2(DEPTH)
) (
  input  stb_entry_t        i_entries [DEPTH],
  input  logic [PW-1:0]     i_head,
  input  logic [STB_AW-1:0] i_addr,
  input  logic              i_skip_head,
  output logic              o_hit,
  output logic [PW-1:0]     o_idx
);

  // Walk the entries from oldest (head) to youngest; a later match overrides an
  // earlier one, so the last match found is the youngest. Valid entries are
  // always contiguous from head, so invalid slots simply never match.
  always_comb begin
    logic [PW-1:0] v_idx;
    o_hit = 1'b0;
    o_idx = '0;
    v_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      v_idx = i_head + PW'(k);
      if (i_entries[v_idx].valid && (i_entries[v_idx].addr == i_addr) &&
          !(i_skip_head && (k == 0))) begin
        o_hit = 1'b1;
        o_idx = v_idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// Posted-write buffer between the MEM stage and a single-port data memory.
// Stores are queued FIFO and drained one per cycle whenever no load uses the
// memory port; loads see the youngest buffered value for their address.
//   clk   : clock, all state on the rising edge
//   rst   : asynchronous, active-low reset
//   bus   : store_buffer_if.slave (store, load and memory ports)
//   count : number of occupied entries
//   empty : count == 0
//   full  : count == DEPTH
// Build option: define STB_MERGE_EN to merge a store into a matching non-head
// entry instead of allocating a new one.
// -----------------------------------------------------------------------------
module store_buffer
  import stb_pkg::*;
#(
  parameter int DEPTH = STB_DEPTH_DEF,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  store_buffer_if.slave  bus,
  output logic [PW:0]    count,
  output logic           empty,
  output logic           full
);

  stb_entry_t    r_entries [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_ld_match;
  logic [PW-1:0] w_ld_idx;
  logic          w_merge_hit;
  logic [PW-1:0] w_merge_idx;
  logic          w_st_fire;
  logic          w_enq;
  logic          w_merge_fire;
  logic          w_deq;

  assign w_full  = (r_count == (PW+1)'(DEPTH));
  assign w_empty = (r_count == '0);

  assign count = r_count;
  assign empty = w_empty;
  assign full  = w_full;

  // Load forwarding looks only at registered entries, so a store accepted in
  // the same cycle is invisible to the (older) load.
  stb_fwd_match #(.DEPTH(DEPTH)) u_ld_match (
    .i_entries   (r_entries),
    .i_head      (r_head),
    .i_addr      (bus.ld_addr),
    .i_skip_head (1'b0),
    .o_hit       (w_ld_match),
    .o_idx       (w_ld_idx)
  );

`ifdef STB_MERGE_EN
  // The head is excluded so a merge can never change data that may be
  // draining in this same cycle.
  stb_fwd_match #(.DEPTH(DEPTH)) u_merge_match (
    .i_entries   (r_entries),
    .i_head      (r_head),
    .i_addr      (bus.st_addr),
    .i_skip_head (1'b1),
    .o_hit       (w_merge_hit),
    .o_idx       (w_merge_idx)
  );
`else
  assign w_merge_hit = 1'b0;
  assign w_merge_idx = '0;
`endif

  assign bus.ld_hit  = bus.ld_valid && w_ld_match;
  assign bus.ld_data = bus.ld_hit ? r_entries[w_ld_idx].data : bus.mem_rd;

  // A drain in the same cycle does not free a slot for the incoming store.
  assign bus.st_ready = rst && (!w_full || w_merge_hit);
  assign w_st_fire    = bus.st_valid && bus.st_ready;
  assign w_merge_fire = w_st_fire && w_merge_hit;
  assign w_enq        = w_st_fire && !w_merge_hit;

  // Loads own the memory port; the drain waits for a load-free cycle.
  assign bus.mem_we   = rst && !w_empty && !bus.ld_valid;
  assign bus.mem_addr = bus.ld_valid ? bus.ld_addr : r_entries[r_head].addr;
  assign bus.mem_wd   = r_entries[r_head].data;
  assign w_deq        = bus.mem_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      // Enqueue and drain never touch the same slot: enqueue needs a free slot
      // (tail != head unless empty) and drain needs a non-empty buffer.
      if (w_deq) begin
        r_entries[r_head].valid <= 1'b0;
        r_head                  <= r_head + 1'b1;
      end
      if (w_enq) begin
        r_entries[r_tail].valid <= 1'b1;
        r_entries[r_tail].addr  <= bus.st_addr;
        r_entries[r_tail].data  <= bus.st_data;
        r_tail                  <= r_tail + 1'b1;
      end
      if (w_merge_fire) begin
        r_entries[w_merge_idx].data <= bus.st_data;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
// Directed bench for store_buffer: a small data-memory model, a write
// scoreboard (expected {addr,data} queue checked on every mem_we) and directed
// vectors with hand-computed expectations. Merge vectors run only when
// STB_MERGE_EN is defined.
// -----------------------------------------------------------------------------
module tb_store_buffer;
  import stb_pkg::*;

  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [$clog2(DEPTH):0] count;
  logic                   empty;
  logic                   full;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q[$];
  logic [31:0] tb_mem [64];
  bit   [63:0] tb_written;

  store_buffer_if bus ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  // Untouched words read back as 0xA000_0000 | index.
  assign bus.mem_rd = tb_written[bus.mem_addr[5:0]] ? tb_mem[bus.mem_addr[5:0]]
                                                    : (32'hA000_0000 | 32'(bus.mem_addr[5:0]));

  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) begin
      tb_mem[bus.mem_addr[5:0]]     <= bus.mem_wd;
      tb_written[bus.mem_addr[5:0]] <= 1'b1;
    end
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- write scoreboard ----------------
  always begin
    @(negedge clk);
    #4;
    if (bus.mem_we === 1'b1) begin
      check("drain_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("drain_word", {bus.mem_addr, bus.mem_wd}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la);
    @(negedge clk);
    bus.st_valid = sv;
    bus.st_addr  = sa;
    bus.st_data  = sd;
    bus.ld_valid = lv;
    bus.ld_addr  = la;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic drain_all(input int max_cycles);
    int n = 0;
    while (empty !== 1'b1 && n < max_cycles) begin
      idle();
      n++;
    end
    check("drain_done", 64'(empty), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not end");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.st_valid = 1'b0;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = '0;

    // Reset
    #1 rst = 1'b0;
    #2;
    check("rst_st_ready", 64'(bus.st_ready), 64'd0);
    check("rst_mem_we",   64'(bus.mem_we),   64'd0);
    check("rst_count",    64'(count),        64'd0);
    check("rst_empty",    64'(empty),        64'd1);
    check("rst_full",     64'(full),         64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // 1. Single store, drains next cycle
    drive(1'b1, 32'd28, 32'h20, 1'b0, 32'd0);
    check("t1_st_ready", 64'(bus.st_ready), 64'd1);
    check("t1_no_bypass", 64'(bus.mem_we), 64'd0);
    exp_q.push_back({32'd28, 32'h20});
    idle();
    check("t1_mem_we",   64'(bus.mem_we),   64'd1);
    check("t1_mem_addr", 64'(bus.mem_addr), 64'd28);
    check("t1_mem_wd",   64'(bus.mem_wd),   64'h20);
    check("t1_count",    64'(count),        64'd1);
    idle();
    check("t1_empty",    64'(empty),        64'd1);
    check("t1_idle_we",  64'(bus.mem_we),   64'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'd28);
    check("t1_ld_hit",   64'(bus.ld_hit),   64'd0);
    check("t1_ld_data",  64'(bus.ld_data),  64'h20);

    // 2. Fill while loads block the drain, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i), 32'h100 + 32'(i), 1'b1, 32'd100);
      check("t2_st_ready", 64'(bus.st_ready), 64'd1);
      check("t2_blocked",  64'(bus.mem_we),   64'd0);
      exp_q.push_back({32'(i), 32'h100 + 32'(i)});
    end
    drive(1'b1, 32'd4, 32'h104, 1'b1, 32'd100);
    check("t2_full",      64'(full),         64'd1);
    check("t2_refused",   64'(bus.st_ready), 64'd0);
    check("t2_count4",    64'(count),        64'd4);
    for (int i = 0; i < 4; i++) begin
      idle();
      check("t2_drain_we",   64'(bus.mem_we),   64'd1);
      check("t2_drain_addr", 64'(bus.mem_addr), 64'(i));
      check("t2_drain_wd",   64'(bus.mem_wd),   64'h100 + 64'(i));
      check("t2_count",      64'(count),        64'(4 - i));
    end
    idle();
    check("t2_empty", 64'(empty), 64'd1);

    // 3. Forwarding: youngest wins, same-cycle store invisible
    drive(1'b1, 32'd40, 32'd1, 1'b1, 32'd40);
    check("t3_same_cyc_hit",  64'(bus.ld_hit),  64'd0);
    check("t3_same_cyc_data", 64'(bus.ld_data), 64'hA000_0028);
    exp_q.push_back({32'd40, 32'd1});
    drive(1'b1, 32'd40, 32'd2, 1'b1, 32'd40);
    check("t3_older_hit",  64'(bus.ld_hit),  64'd1);
    check("t3_older_data", 64'(bus.ld_data), 64'd1);
    exp_q.push_back({32'd40, 32'd2});
    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'd40);
    check("t3_young_hit",  64'(bus.ld_hit),  64'd1);
    check("t3_young_data", 64'(bus.ld_data), 64'd2);
    check("t3_count",      64'(count),       64'd2);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'd44);
    check("t3_miss_hit",  64'(bus.ld_hit),  64'd0);
    check("t3_miss_data", 64'(bus.ld_data), 64'hA000_002C);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd40);
    check("t3_no_ld_hit", 64'(bus.ld_hit), 64'd0);
    drain_all(8);

    // 4. Full buffer: refused store during drain, then store+drain with wrap
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'd8 + 32'(i), 32'h200 + 32'(i), 1'b1, 32'd100);
      exp_q.push_back({32'd8 + 32'(i), 32'h200 + 32'(i)});
    end
    drive(1'b1, 32'd12, 32'h20C, 1'b0, 32'd0);
    check("t4_full_refuse", 64'(bus.st_ready), 64'd0);
    check("t4_drain_we",    64'(bus.mem_we),   64'd1);
    check("t4_drain_addr",  64'(bus.mem_addr), 64'd8);
    check("t4_count4",      64'(count),        64'd4);
    drive(1'b1, 32'd12, 32'h20C, 1'b0, 32'd0);
    check("t4_count3",      64'(count),        64'd3);
    check("t4_accept",      64'(bus.st_ready), 64'd1);
    check("t4_drain_addr2", 64'(bus.mem_addr), 64'd9);
    exp_q.push_back({32'd12, 32'h20C});
    idle();
    check("t4_count_same",  64'(count),        64'd3);
    check("t4_drain_addr3", 64'(bus.mem_addr), 64'd10);
    drain_all(8);

    // 5. Reset while draining discards queued stores
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'd16 + 32'(i), 32'h400 + 32'(i), 1'b1, 32'd100);
      exp_q.push_back({32'd16 + 32'(i), 32'h400 + 32'(i)});
    end
    idle();
    check("t5_pre_we",   64'(bus.mem_we),   64'd1);
    check("t5_pre_addr", 64'(bus.mem_addr), 64'd16);
    #1;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("t5_rst_we",    64'(bus.mem_we),   64'd0);
    check("t5_rst_count", 64'(count),        64'd0);
    check("t5_rst_ready", 64'(bus.st_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      check("t5_no_stale_we", 64'(bus.mem_we), 64'd0);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'd16);
    check("t5_mem_untouched", 64'(bus.ld_data), 64'hA000_0010);
    check("t5_ld_miss",       64'(bus.ld_hit),  64'd0);

`ifdef STB_MERGE_EN
    // 6. Merge into a non-head entry while full
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'd20 + 32'(i), 32'h300 + 32'(i), 1'b1, 32'd100);
      exp_q.push_back({32'd20 + 32'(i), 32'h300 + 32'(i)});
    end
    drive(1'b1, 32'd22, 32'h3FF, 1'b1, 32'd100);
    check("t6_merge_ready", 64'(bus.st_ready), 64'd1);
    check("t6_full",        64'(full),         64'd1);
    exp_q[2] = {32'd22, 32'h3FF};
    drive(1'b1, 32'd20, 32'h3EE, 1'b1, 32'd20);
    check("t6_count_same",  64'(count),        64'd4);
    check("t6_head_refuse", 64'(bus.st_ready), 64'd0);
    check("t6_head_hit",    64'(bus.ld_hit),   64'd1);
    check("t6_head_data",   64'(bus.ld_data),  64'h300);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'd22);
    check("t6_merged_data", 64'(bus.ld_data),  64'h3FF);
    drain_all(8);
`endif

    idle();
    check("sb_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
